// File: rtl/mt6835_spi_emulator_if.sv
// SPI bus between an external mode-3 master and the MT6835 emulator.
interface mt6835_spi_emulator_if;
    logic spi_clk;
    logic spi_cs;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (output spi_clk, output spi_cs, output spi_mosi,
                    input spi_miso, input spi_miso_oe);
    modport slave  (input spi_clk, input spi_cs, input spi_mosi,
                    output spi_miso, output spi_miso_oe);
endinterface

// File: rtl/mt6835_spi_emulator.sv
// MT6835 angle-sensor SPI slave emulator (mode 3, burst angle read, command 0xA).
// Optional MT6835_CRC_EN: register 0x006 returns CRC-8 (poly 0x07) of bytes 0x003..0x005.
module mt6835_spi_emulator (
    input  logic                        i_clk,
    input  logic                        rstn,
    mt6835_spi_emulator_if.slave        spi,
    input  logic [20:0]                 i_angle,
    input  logic [2:0]                  i_status,
    output logic                        o_frame_done,
    output logic                        o_cmd_err
);
    typedef enum logic [2:0] {WAIT_CS, IDLE, CMD, DATA, IGNORE} state_t;

    state_t      state, state_n;
    logic [1:0]  clk_sync, cs_sync, mosi_sync;
    logic        clk_d, cs_d;
    logic        clk_s, cs_s, mosi_s;
    logic        clk_rise, clk_fall, cs_rise, cs_fall;
    logic [1:0]  settle_cnt;
    logic        settle_done;
    logic [3:0]  bit_cnt;
    logic [14:0] cmd_sr;
    logic [15:0] cmd_word;
    logic [11:0] ptr;
    logic [20:0] angle_q;
    logic [2:0]  status_q;
    logic [7:0]  rd_byte;
    logic        miso_q, oe_q;
    logic        shift_in, shift_out, decode_ok, decode_err;

`ifdef MT6835_CRC_EN
    logic [7:0]  crc_q;

    function automatic logic [7:0] crc8(input logic [23:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 23; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction
`endif

    assign clk_s       = clk_sync[1];
    assign cs_s        = cs_sync[1];
    assign mosi_s      = mosi_sync[1];
    assign clk_rise    = clk_s & ~clk_d;
    assign clk_fall    = ~clk_s & clk_d;
    assign cs_rise     = cs_s & ~cs_d;
    assign cs_fall     = ~cs_s & cs_d;
    assign settle_done = &settle_cnt;
    assign cmd_word    = {cmd_sr, mosi_s};

    assign spi.spi_miso    = miso_q;
    assign spi.spi_miso_oe = oe_q;

    always_ff @(posedge i_clk) begin
        if (!rstn) begin
            clk_sync  <= 2'b11;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b11;
            clk_d     <= 1'b1;
            cs_d      <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], spi.spi_clk};
            cs_sync   <= {cs_sync[0], spi.spi_cs};
            mosi_sync <= {mosi_sync[0], spi.spi_mosi};
            clk_d     <= clk_s;
            cs_d      <= cs_s;
        end
    end

    // WAIT_CS also waits for the reset-preset synchronizers to flush, so a CS
    // already low at reset release is never mistaken for a fresh falling edge.
    always_comb begin
        state_n    = state;
        shift_in   = 1'b0;
        shift_out  = 1'b0;
        decode_ok  = 1'b0;
        decode_err = 1'b0;
        if (cs_rise) begin
            state_n = IDLE;
        end else begin
            case (state)
                WAIT_CS: if (settle_done && cs_s) state_n = IDLE;
                IDLE:    if (cs_fall) state_n = CMD;
                CMD: begin
                    if (clk_rise) begin
                        shift_in = 1'b1;
                        if (bit_cnt == 4'd15) begin
                            if (cmd_word[15:12] == 4'hA) begin
                                decode_ok = 1'b1;
                                state_n   = DATA;
                            end else begin
                                decode_err = 1'b1;
                                state_n    = IGNORE;
                            end
                        end
                    end
                end
                DATA:    if (clk_fall) shift_out = 1'b1;
                IGNORE:  state_n = IGNORE;
                default: state_n = WAIT_CS;
            endcase
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        case (ptr)
            12'h003: rd_byte = angle_q[20:13];
            12'h004: rd_byte = angle_q[12:5];
            12'h005: rd_byte = {angle_q[4:0], status_q};
`ifdef MT6835_CRC_EN
            12'h006: rd_byte = crc_q;
`endif
            default: rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!rstn) begin
            state        <= WAIT_CS;
            settle_cnt   <= 2'd0;
            bit_cnt      <= 4'd0;
            cmd_sr       <= 15'd0;
            ptr          <= 12'd0;
            angle_q      <= 21'd0;
            status_q     <= 3'd0;
            miso_q       <= 1'b1;
            oe_q         <= 1'b0;
            o_frame_done <= 1'b0;
            o_cmd_err    <= 1'b0;
`ifdef MT6835_CRC_EN
            crc_q        <= 8'h00;
`endif
        end else begin
            state        <= state_n;
            o_frame_done <= cs_rise && (state == DATA);
            o_cmd_err    <= decode_err;
            oe_q         <= (state_n == CMD) || (state_n == DATA);

            if (state == WAIT_CS && !settle_done) settle_cnt <= settle_cnt + 2'd1;

            if (cs_rise || (state == IDLE && cs_fall)) begin
                bit_cnt <= 4'd0;
                cmd_sr  <= 15'd0;
            end else if (shift_in) begin
                cmd_sr  <= cmd_word[14:0];
                bit_cnt <= bit_cnt + 4'd1;
            end else if (shift_out) begin
                if (bit_cnt == 4'd7) begin
                    bit_cnt <= 4'd0;
                    if (ptr != 12'hFFF) ptr <= ptr + 12'd1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end

            if (decode_ok) begin
                ptr      <= cmd_word[11:0];
                angle_q  <= i_angle;
                status_q <= i_status;
`ifdef MT6835_CRC_EN
                crc_q    <= crc8({i_angle, i_status});
`endif
            end

            if (shift_out)
                miso_q <= rd_byte[3'd7 - bit_cnt[2:0]];
            else if (state_n != DATA)
                miso_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mt6835_spi_emulator.sv
// Randomized scoreboard bench for mt6835_spi_emulator; a pin-level monitor checks MISO bytes.
module tb_mt6835_spi_emulator;
    logic        i_clk = 1'b0;
    logic        rstn;
    logic [20:0] angle;
    logic [2:0]  status;
    logic        frame_done, cmd_err;

    mt6835_spi_emulator_if bus();

    mt6835_spi_emulator dut (
        .i_clk        (i_clk),
        .rstn         (rstn),
        .spi          (bus),
        .i_angle      (angle),
        .i_status     (status),
        .o_frame_done (frame_done),
        .o_cmd_err    (cmd_err)
    );

    always #5 i_clk = ~i_clk;

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    bit         mon_en = 1'b1;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hw(input int n);
        repeat (n) @(negedge i_clk);
    endtask

`ifdef MT6835_CRC_EN
    function automatic logic [7:0] model_crc(input logic [23:0] w);
        logic [7:0] crc;
        logic [7:0] b;
        crc = 8'h00;
        for (int k = 0; k < 3; k++) begin
            b = w[23 - 8*k -: 8];
            crc = crc ^ b;
            for (int j = 0; j < 8; j++)
                crc = crc[7] ? ((crc << 1) ^ 8'h07) : (crc << 1);
        end
        return crc;
    endfunction
`endif

    // Register map view: 0x003..0x005 are the 24-bit {angle,status} word split into bytes.
    function automatic logic [7:0] model_reg(input int addr, input logic [20:0] a, input logic [2:0] s);
        logic [23:0] w;
        w = {a, s};
        if (addr == 3) return w[23:16];
        if (addr == 4) return w[15:8];
        if (addr == 5) return w[7:0];
`ifdef MT6835_CRC_EN
        if (addr == 6) return model_crc(w);
`endif
        return 8'h00;
    endfunction

    task automatic push_exp(input int addr, input int n);
        int a;
        for (int i = 0; i < n; i++) begin
            a = addr + i;
            if (a > 4095) a = 4095;
            exp_q.push_back(model_reg(a, angle, status));
        end
    endtask

    always @(negedge i_clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (cmd_err === 1'b1) err_cnt++;
    end

    // Monitor: decodes the command from MOSI and samples MISO on master rising edges.
    initial begin
        int          nbits;
        bit          active;
        logic [15:0] cmdw;
        logic [7:0]  rx;
        logic [7:0]  e;
        forever begin
            @(negedge bus.spi_cs);
            active = mon_en;
            nbits  = 0;
            cmdw   = 16'h0;
            rx     = 8'h0;
            forever begin
                @(posedge bus.spi_clk or posedge bus.spi_cs);
                if (bus.spi_cs === 1'b1) break;
                if (!active) continue;
                if (nbits < 16) begin
                    cmdw = {cmdw[14:0], bus.spi_mosi};
                    if (nbits == 15) chk("cmd_phase_miso", bus.spi_miso, 1'b0);
                end else if (cmdw[15:12] == 4'hA) begin
                    rx = {rx[6:0], bus.spi_miso};
                    if (((nbits - 16) % 8) == 7) begin
                        chk("data_oe", bus.spi_miso_oe, 1'b1);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_byte: got %0h expected none", rx);
                        end else begin
                            e = exp_q.pop_front();
                            chk("miso_byte", rx, e);
                        end
                    end
                end else begin
                    chk("ignore_oe", bus.spi_miso_oe, 1'b0);
                    chk("ignore_miso", bus.spi_miso, 1'b0);
                end
                nbits++;
            end
        end
    end

    task automatic run_frame(input logic [15:0] cmd, input int ndata, input int half,
                             input int stop_bits, input int chg_bit, input int rst_bit);
        int nbits;
        bit post_rst;
        post_rst = 1'b0;
        nbits = (stop_bits >= 0) ? stop_bits : 16 + 8*ndata;
        bus.spi_cs = 1'b0;
        hw(half);
        for (int i = 0; i < nbits; i++) begin
            bus.spi_clk  = 1'b0;
            bus.spi_mosi = (i < 16) ? cmd[15-i] : (($urandom & 1) != 0);
            if (i == chg_bit) begin
                angle  = 21'($urandom);
                status = 3'($urandom);
            end
            if (i == rst_bit) begin
                rstn = 1'b0;
                hw(2);
                chk("midrst_miso", bus.spi_miso, 1'b1);
                chk("midrst_oe", bus.spi_miso_oe, 1'b0);
                rstn = 1'b1;
                hw(1);
                post_rst = 1'b1;
            end
            hw(half);
            if (post_rst) begin
                chk("postrst_miso", bus.spi_miso, 1'b0);
                chk("postrst_oe", bus.spi_miso_oe, 1'b0);
            end
            bus.spi_clk = 1'b1;
            hw(half);
        end
        hw(half);
        bus.spi_cs = 1'b1;
        hw(2*half + 6);
    endtask

    task automatic expect_frame(input string name, input int d_done, input int d_err,
                                input int done0, input int err0);
        chk({name, "_frame_done"}, done_cnt - done0, d_done);
        chk({name, "_cmd_err"}, err_cnt - err0, d_err);
        chk({name, "_queue_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int          d0, e0, addr, n, half;
        logic [3:0]  c;
        rstn         = 1'b0;
        bus.spi_cs   = 1'b1;
        bus.spi_clk  = 1'b1;
        bus.spi_mosi = 1'b1;
        angle        = 21'd0;
        status       = 3'd0;
        hw(3);
        chk("rst_miso", bus.spi_miso, 1'b1);
        chk("rst_oe", bus.spi_miso_oe, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_cmd_err", cmd_err, 1'b0);
        rstn = 1'b1;
        hw(10);
        chk("idle_oe", bus.spi_miso_oe, 1'b0);

        // Reference burst from 0x003
        angle = 21'h1ABCDE; status = 3'b101;
        d0 = done_cnt; e0 = err_cnt;
        push_exp(3, 4);
        run_frame(16'hA003, 4, 8, -1, -1, -1);
        expect_frame("ref", 1, 0, d0, e0);

        // Angle changes after decode: bytes come from the snapshot
        angle = 21'($urandom); status = 3'($urandom);
        d0 = done_cnt; e0 = err_cnt;
        push_exp(3, 4);
        run_frame(16'hA003, 4, 6, -1, 20, -1);
        expect_frame("snapshot", 1, 0, d0, e0);

        // Rejected command
        d0 = done_cnt; e0 = err_cnt;
        run_frame(16'h3003, 2, 5, -1, -1, -1);
        expect_frame("bad_cmd", 0, 1, d0, e0);

        // Burst starting at 0x005
        d0 = done_cnt; e0 = err_cnt;
        push_exp(5, 4);
        run_frame(16'hA005, 4, 4, -1, -1, -1);
        expect_frame("addr5", 1, 0, d0, e0);

        // Abort inside command, then a good frame
        d0 = done_cnt; e0 = err_cnt;
        run_frame(16'hA003, 0, 6, 10, -1, -1);
        expect_frame("abort", 0, 0, d0, e0);
        d0 = done_cnt; e0 = err_cnt;
        push_exp(3, 3);
        run_frame(16'hA003, 3, 6, -1, -1, -1);
        expect_frame("after_abort", 1, 0, d0, e0);

        // Pointer saturates at 0xFFF instead of wrapping into the angle bytes
        angle = 21'h1FFFFF; status = 3'b111;
        d0 = done_cnt; e0 = err_cnt;
        push_exp(12'hFFD, 8);
        run_frame(16'hAFFD, 8, 4, -1, -1, -1);
        expect_frame("saturate", 1, 0, d0, e0);

        // Reset during DATA with CS still low
        mon_en = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        run_frame(16'hA003, 4, 6, -1, -1, 24);
        expect_frame("reset_mid", 0, 0, d0, e0);
        mon_en = 1'b1;
        angle = 21'($urandom); status = 3'($urandom);
        d0 = done_cnt; e0 = err_cnt;
        push_exp(3, 4);
        run_frame(16'hA003, 4, 6, -1, -1, -1);
        expect_frame("after_reset", 1, 0, d0, e0);

        // Randomized frames
        for (int k = 0; k < 20; k++) begin
            angle  = 21'($urandom);
            status = 3'($urandom);
            addr   = ($urandom_range(1, 0) == 1) ? int'($urandom_range(8, 0)) : int'($urandom_range(4095, 0));
            n      = $urandom_range(4, 1);
            half   = $urandom_range(8, 4);
            d0 = done_cnt; e0 = err_cnt;
            if ($urandom_range(4, 0) != 0) begin
                push_exp(addr, n);
                run_frame({4'hA, 12'(addr)}, n, half, -1, -1, -1);
                expect_frame("rand_read", 1, 0, d0, e0);
            end else begin
                c = 4'($urandom);
                if (c == 4'hA) c = 4'h5;
                run_frame({c, 12'(addr)}, n, half, -1, -1, -1);
                expect_frame("rand_bad", 0, 1, d0, e0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mt6835_spi_emulator.md
MT6835_SPI_EMULATOR -- requirements
Module: mt6835_spi_emulator

Interface
REQ-001 SHALL have i_clk, input, 1, system clock; all logic on its rising edge.
REQ-002 SHALL have rstn, input, 1, synchronous active-low reset, sampled on i_clk rising edge.
REQ-003 SHALL have spi_clk, input, 1, SPI clock from the master, mode 3 (CPOL=1, CPHA=1), asynchronous to i_clk.
REQ-004 SHALL have spi_cs, input, 1, active-low chip select, asynchronous.
REQ-005 SHALL have spi_mosi, input, 1, master-to-slave data, MSB first.
REQ-006 SHALL have spi_miso, output, 1, slave-to-master data, MSB first.
REQ-007 SHALL have spi_miso_oe, output, 1, MISO drive enable; 1 only while in CMD or DATA with spi_cs low.
REQ-008 SHALL have i_angle, input, 21, emulated angle.
REQ-009 SHALL have i_status, input, 3, emulated status bits.
REQ-010 SHALL have o_frame_done, output, 1, one-cycle pulse when a burst frame ends.
REQ-011 SHALL have o_cmd_err, output, 1, one-cycle pulse when a command is rejected.

Function
REQ-012 SHALL pass spi_clk, spi_cs and spi_mosi through 2-flop synchronizers, then detect edges on the synchronized values; this requires at least 4 i_clk cycles per SPI half-bit.
REQ-013 SHALL sample spi_mosi on detected spi_clk rising edges and update spi_miso on detected falling edges.
REQ-014 SHALL implement states WAIT_CS, IDLE, CMD, DATA and IGNORE.
REQ-015 WAIT_CS: SHALL leave to IDLE only once synchronized spi_cs is high.
REQ-016 IDLE: spi_cs falling edge SHALL move to CMD and clear the bit counter.
REQ-017 CMD: SHALL shift 16 bits in, {cmd[3:0], addr[11:0]}, decoded on the 16th rising edge.
REQ-018 If cmd==4'hA, the block SHALL load the address pointer with addr, snapshot i_angle and i_status into holding registers, and enter DATA.
REQ-019 If cmd!=4'hA, the block SHALL pulse o_cmd_err and enter IGNORE.
REQ-020 Register map (read-only): 0x003={angle[20:13]}, 0x004={angle[12:5]}, 0x005={angle[4:0],status[2:0]}, 0x006=CRC byte (see REQ-029). All other addresses SHALL read 0x00.
REQ-021 DATA: the MSB of the addressed byte SHALL be driven on the first falling edge after the 16th rising edge; the remaining 7 bits follow on subsequent falling edges.
REQ-022 DATA: after each 8th bit, the pointer SHALL increment; addresses above 0x006 read 0x00; the pointer SHALL saturate at 12'hFFF and never wrap.
REQ-023 Holding registers SHALL stay constant for the whole frame, so every byte in a burst is coherent.
REQ-024 A spi_cs rising edge in any state SHALL return to IDLE and clear the bit counter; if the state was DATA, o_frame_done SHALL pulse one cycle later.
REQ-025 IGNORE: spi_miso SHALL be 0 and spi_miso_oe 0 until spi_cs rises.
REQ-026 CMD phase: spi_miso SHALL be 0.
REQ-027 A frame aborted in CMD (fewer than 16 bits) SHALL pulse neither o_frame_done nor o_cmd_err.

Reset
REQ-028 rstn low SHALL force the state to WAIT_CS and set spi_miso=1, spi_miso_oe=0, o_frame_done=0, o_cmd_err=0, pointer, counters and holding registers to 0, and synchronizer flops to 1; a frame already in progress when reset releases SHALL be ignored until spi_cs goes high.

Configuration
REQ-029 Macro MT6835_CRC_EN: when defined, register 0x006 SHALL be CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR) over bytes 0x003,0x004,0x005 MSB first, computed from the snapshot before the first data bit. When undefined, 0x006 SHALL read 0x00 and no CRC logic SHALL be present.

Verification
REQ-030 Angle 0x1ABCDE, status 3'b101, command A0 03 plus 4 dummy bytes, 8 i_clk per half-bit -> MISO bytes D5 E6 F5 then 00 (CRC off) or the model CRC-8 of D5 E6 F5 (CRC on); o_frame_done pulses once.
REQ-031 Angle changed mid-frame after the command -> all data bytes reflect the snapshot taken at command decode.
REQ-032 Command 0x30 0x03 -> o_cmd_err pulses once, spi_miso_oe stays 0, no o_frame_done.
REQ-033 Burst from addr 0x005 with 4 data bytes -> F5, CRC/00, 00, 00.
REQ-034 CS raised after 10 command bits, then a valid frame -> no pulses for the aborted frame; the second frame returns correct bytes.
REQ-035 rstn asserted mid-DATA, released with CS still low -> MISO held 0/oe 0 until CS rises; the next frame is correct.
